// File: rtl/frame_stream_controller.sv
// Frame sequencer for the loader/gaussian/loader/gradient chain:
// streams source pixels, flushes line buffers, then counts outputs.
module frame_stream_controller #(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int FLUSH_LEN  = 1026,
    parameter int EXPECT_OUT = 262144,
    parameter int TIMEOUT    = 4096
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            start,
    input  logic [7:0]                      src_pixel,
    input  logic                            src_valid,
    output logic                            src_ready,
    output logic [7:0]                      pix_out,
    output logic                            pix_out_valid,
    input  logic                            pipe_out_valid,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err_timeout,
    output logic [$clog2(EXPECT_OUT+1)-1:0] out_count
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int OW = $clog2(EXPECT_OUT + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(EXPECT_OUT);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [FW-1:0] flush_cnt;
    logic [TW-1:0] to_cnt;

    logic accept;
    logic last_px;
    logic flush_end;
    logic to_hit;
    logic complete;
    logic frame_go;
    logic counting;

    assign accept    = src_valid && src_ready;
    assign last_px   = accept && (row == ROW_LAST) && (col == COL_LAST);
    assign flush_end = (flush_cnt == FLUSH_LAST);
    // A pulse on the deciding cycle resets the gap, so it never times out.
    assign to_hit    = !pipe_out_valid && (to_cnt == TO_LAST);
    assign complete  = (out_count == OUT_MAX);
    assign frame_go  = (state == IDLE) && start;
    assign counting  = (state == STREAM) || (state == FLUSH) ||
                       (state == DRAIN);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = STREAM;
            STREAM: begin
                if (last_px)
                    state_next = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
            end
            FLUSH:  if (flush_end) state_next = DRAIN;
            DRAIN:  if (complete || to_hit) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready  = (state == STREAM);
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pix_out       <= 8'd0;
            pix_out_valid <= 1'b0;
        end else begin
            pix_out_valid <= 1'b0;
            if (accept) begin
                pix_out       <= src_pixel;
                pix_out_valid <= 1'b1;
            end else if (state == FLUSH) begin
                pix_out       <= 8'd0;
                pix_out_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col <= '0;
            row <= '0;
        end else if (frame_go) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            flush_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            if (state == FLUSH)
                flush_cnt <= flush_end ? '0 : flush_cnt + FW'(1);
            else
                flush_cnt <= '0;
            if (state == DRAIN)
                to_cnt <= pipe_out_valid ? '0 : to_cnt + TW'(1);
            else
                to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_count   <= '0;
            err_timeout <= 1'b0;
        end else if (frame_go) begin
            out_count   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (counting && pipe_out_valid && !complete)
                out_count <= out_count + OW'(1);
            if ((state == DRAIN) && !complete && to_hit)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_stream_controller.sv
// Self-checking bench for frame_stream_controller on a 4x3 frame
// against a phase/count reference model.
module tb_frame_stream_controller;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FL = 5;
    localparam int EO = 12;
    localparam int TO = 8;
    localparam int N  = W * H;
    localparam int OW = $clog2(EO + 1);

    localparam int P_IDLE = 0;
    localparam int P_IN   = 1;
    localparam int P_ZERO = 2;
    localparam int P_WAIT = 3;
    localparam int P_END  = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [7:0]    src_pixel;
    logic          src_valid;
    logic          src_ready;
    logic [7:0]    pix_out;
    logic          pix_out_valid;
    logic          pipe_out_valid;
    logic          busy;
    logic          frame_done;
    logic          err_timeout;
    logic [OW-1:0] out_count;

    int n_asserts = 0;
    int fails = 0;

    int       ph;
    int       acc;
    int       zl;
    int       gap;
    int       ocnt;
    bit       err;
    bit       ev;
    bit [7:0] ep;
    bit       dq[$];

    frame_stream_controller #(
        .IMG_W(W), .IMG_H(H), .FLUSH_LEN(FL),
        .EXPECT_OUT(EO), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .start(start),
        .src_pixel(src_pixel),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .pix_out(pix_out),
        .pix_out_valid(pix_out_valid),
        .pipe_out_valid(pipe_out_valid),
        .busy(busy),
        .frame_done(frame_done),
        .err_timeout(err_timeout),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; acc = 0; zl = 0; gap = 0;
        ocnt = 0; err = 1'b0; ev = 1'b0; ep = 8'd0;
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_edge();
        bit nev = 1'b0;
        bit cnt = 1'b0;
        case (ph)
            P_IDLE: if (start) begin
                ph = P_IN; acc = 0; ocnt = 0; err = 1'b0;
            end
            P_IN: begin
                cnt = 1'b1;
                if (src_valid) begin
                    nev = 1'b1; ep = src_pixel; acc++;
                    if (acc == N) begin
                        ph = P_ZERO; zl = FL;
                    end
                end
            end
            P_ZERO: begin
                cnt = 1'b1; nev = 1'b1; ep = 8'd0; zl--;
                if (zl == 0) begin
                    ph = P_WAIT; gap = 0;
                end
            end
            P_WAIT: begin
                cnt = 1'b1;
                if (ocnt == EO) ph = P_END;
                else if (!pipe_out_valid && gap + 1 == TO) begin
                    err = 1'b1; ph = P_END;
                end else gap = pipe_out_valid ? 0 : gap + 1;
            end
            default: ph = P_IDLE;
        endcase
        if (cnt && pipe_out_valid && ocnt < EO) ocnt++;
        ev = nev;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("busy", busy, ph != P_IDLE);
        chk("src_ready", src_ready, ph == P_IN);
        chk("pix_out_valid", pix_out_valid, ev);
        if (ev || ph == P_IN) chk("pix_out", pix_out, ep);
        chk("frame_done", frame_done, ph == P_END);
        chk("out_count", out_count, ocnt);
        chk("err_timeout", err_timeout, err);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int pulses, input int maxgap);
        dq.delete();
        for (int i = 0; i < pulses; i++) begin
            repeat ($urandom_range(0, maxgap)) dq.push_back(1'b0);
            dq.push_back(1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            src_valid = 1'($urandom_range(0, 1));
            src_pixel = 8'($urandom);
            pipe_out_valid = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // vmode: 0 = always valid with pixels 1..N, 1 = toggling, 2 = random
    task automatic run_frame(input int vmode, input int spulses,
                             input bit noise);
        int cyc = 0;
        int k = 0;
        int sp = spulses;
        start = 1'b1; src_valid = 1'b0; pipe_out_valid = 1'b0;
        tick();
        while (ph != P_IDLE && cyc < 500) begin
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            src_valid = 1'b0;
            src_pixel = 8'($urandom);
            pipe_out_valid = 1'b0;
            if (ph == P_IN) begin
                case (vmode)
                    0: begin src_valid = 1'b1; src_pixel = 8'(acc + 1); end
                    1: src_valid = (k % 2 == 0);
                    default: src_valid = 1'($urandom_range(0, 1));
                endcase
                k++;
                if (sp > 0) begin pipe_out_valid = 1'b1; sp--; end
            end else if (ph == P_WAIT) begin
                if (dq.size() > 0) pipe_out_valid = dq.pop_front();
            end else if (ph == P_END && noise) begin
                start = 1'b1; pipe_out_valid = 1'b1;
            end
            tick();
            cyc++;
        end
        if (cyc >= 500) begin
            fails++;
            $error("FAIL frame_bound: observed %0d cycles expected < 500", cyc);
        end
    endtask

    initial begin
        rstN = 1'b0; start = 1'b0; src_valid = 1'b0;
        src_pixel = 8'd0; pipe_out_valid = 1'b0;
        model_reset();
        #2;
        repeat (2) tick();
        rstN = 1'b1;
        idle(2);

        // abort mid-stream after 5 accepts
        start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_valid = 1'b1; src_pixel = 8'($urandom);
            pipe_out_valid = 1'b1;
            tick();
        end
        rstN = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_pix_valid", pix_out_valid, 1'b0);
        chk("rst_pix", pix_out, 8'd0);
        chk("rst_out_count", out_count, 0);
        chk("rst_src_ready", src_ready, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        model_reset();
        src_valid = 1'b0; pipe_out_valid = 1'b0;
        tick();
        rstN = 1'b1;
        idle(1);

        // clean frame, pixels 1..12, all outputs returned
        fill(EO, 2);
        run_frame(0, 0, 1'b0);
        idle(3);
        chk("f2_out_count", out_count, EO);
        chk("f2_err", err_timeout, 1'b0);

        // toggling valid
        fill(EO, 3);
        run_frame(1, 0, 1'b0);
        idle(2);

        // only 10 outputs -> timeout
        fill(10, 2);
        run_frame(2, 0, 1'b0);
        idle(3);
        chk("f4_err", err_timeout, 1'b1);
        chk("f4_out_count", out_count, 10);

        // 12th output lands on the cycle the timeout would fire
        dq.delete();
        repeat (11) dq.push_back(1'b1);
        repeat (TO - 1) dq.push_back(1'b0);
        dq.push_back(1'b1);
        run_frame(2, 0, 1'b0);
        idle(2);
        chk("f5_err", err_timeout, 1'b0);
        chk("f5_out_count", out_count, EO);

        // 15 outputs during STREAM saturate the counter
        dq.delete();
        run_frame(1, 15, 1'b0);
        idle(2);
        chk("f5b_out_count", out_count, EO);

        // start noise in active states and in DONE
        fill(EO, 3);
        run_frame(2, 0, 1'b1);
        idle(3);

        for (int f = 0; f < 4; f++) begin
            fill($urandom_range(8, EO), $urandom_range(2, 9));
            run_frame($urandom_range(0, 2), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)));
            idle($urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, fails);
        $finish;
    end

endmodule

// File: doc/frame_stream_controller.md
Name: frame_stream_controller

Overview:
- Sequences one full frame through the pixel_loader, gaussian_filter, pixel_loader and gradient_calculation streaming chain.
- Accepts source pixels over a valid/ready handshake, tracks row and column, and forwards them as a registered pixel stream.
- After the last pixel it injects zero flush pixels to drain the line buffers, then counts pipeline outputs until the frame is complete.
- Reports frame_done and a sticky timeout error; sits between the image source (memory or DMA) and the first pixel_loader.

Parameters:
IMG_W, 512, pixels per row
IMG_H, 512, rows per frame
FLUSH_LEN, 1026, zero pixels injected after the last source pixel
EXPECT_OUT, 262144, pipeline output pixels expected per frame
TIMEOUT, 4096, max consecutive DRAIN cycles without pipe_out_valid

Ports:
clk  in  1  clock, all logic on posedge
rstN  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start request
src_pixel  in  8  source pixel
src_valid  in  1  source pixel valid
src_ready  out  1  controller accepts source pixel
pix_out  out  8  pixel to first pixel_loader (pixel_in)
pix_out_valid  out  1  pixel_in_valid to pipeline
pipe_out_valid  in  1  gradient_out_valid from pipeline end
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at frame end
err_timeout  out  1  sticky drain-timeout flag
out_count  out  $clog2(EXPECT_OUT+1)  outputs counted this frame

Behaviour:
- Reset (rstN=0, asynchronous): state=IDLE; row, col, flush and timeout counters = 0.
- Reset outputs: src_ready=0, pix_out=0, pix_out_valid=0, busy=0, frame_done=0, err_timeout=0, out_count=0.
- Reset mid-frame aborts immediately; nothing resumes.
- FSM states: IDLE, STREAM, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 -> STREAM.
  - Same edge: clear row, col, out_count and err_timeout.
- start is ignored in every other state.
- STREAM:
  - src_ready=1 (combinational from state).
  - Accept when src_valid && src_ready: pix_out<=src_pixel and pix_out_valid<=1 on that edge, so latency is 1 cycle.
  - Cycle without accept: pix_out_valid<=0 and pix_out holds its value.
  - Per accept: col++; at col==IMG_W-1, col wraps to 0 and row++.
  - Accept at row==IMG_H-1, col==IMG_W-1 -> FLUSH; row and col return to 0.
- FLUSH:
  - src_ready=0.
  - Each cycle: pix_out<=0, pix_out_valid<=1.
  - Exactly FLUSH_LEN valid zero pixels, then -> DRAIN.
  - FLUSH_LEN=0 goes straight to DRAIN with no flush pixel.
- DRAIN:
  - pix_out_valid<=0.
  - Timeout counter resets on pipe_out_valid and increments otherwise.
  - out_count==EXPECT_OUT -> DONE.
  - Timeout counter reaching TIMEOUT -> err_timeout<=1, then -> DONE.
  - If both conditions hold on the same cycle, completion wins and err_timeout stays 0.
- DONE: frame_done=1 for exactly one cycle, then -> IDLE. busy drops in IDLE.
- out_count:
  - Increments on pipe_out_valid in STREAM, FLUSH and DRAIN.
  - Saturates at EXPECT_OUT; further pulses are ignored.
  - Holds its value through IDLE until the next start.
- pipe_out_valid in IDLE or DONE is ignored.
- Counters are unsigned and sized by $clog2 of their maximum value; wrap only as defined above.

Test Plan:
Use IMG_W=4, IMG_H=3, FLUSH_LEN=5, EXPECT_OUT=12, TIMEOUT=8 unless noted.
1. Reset mid-STREAM after 5 accepts -> next cycle state IDLE, busy=0, pix_out_valid=0, out_count=0; a new start runs a clean frame.
2. start, src_valid held high with pixels 1..12, pipeline model returns 12 pipe_out_valid in DRAIN -> pix_out=1..12 on consecutive cycles, each one cycle after acceptance, then exactly 5 zero pixels, frame_done single pulse, out_count=12, err_timeout=0.
3. src_valid toggles 1,0,1,0 -> pix_out_valid mirrors with 1-cycle delay, col/row wrap correct, FLUSH entered only after the 12th accept.
4. Only 10 pipe_out_valid pulses returned -> 8 idle DRAIN cycles, err_timeout=1, frame_done pulses, out_count=10; err_timeout clears on next start.
5. 12th pipe_out_valid on the same cycle the timeout is reached -> DONE with err_timeout=0; 3 extra pipe_out_valid pulses in STREAM keep out_count saturated at 12.
6. start asserted during STREAM and DRAIN -> ignored, no counter clear; start in the DONE cycle -> ignored, controller returns to IDLE.
